param_shift_register: RTL and testbench
=======================================

Name: param_shift_register

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with enable and eight operating modes (hold, parallel load, logical and arithmetic shifts, rotates, clear).
- Includes serial in/out at both ends and a shift counter that flags when a loaded word has been fully shifted out.
- Used as the generic storage/serialiser element in datapaths and serial links.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately; released synchronously by the environment).
- en  input  1  clock enable; when 0 every register holds regardless of mode.
- mode  input  3  operation select, sampled on the clk edge (encoding below).
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering at bit 0 on a left shift.
- sin_l  input  1  serial input entering at bit WIDTH-1 on a logical right shift.
- q  output  WIDTH  register contents.
- sout_l  output  1  equals q[WIDTH-1] (combinational from q).
- sout_r  output  1  equals q[0] (combinational from q).
- shift_cnt  output  $clog2(WIDTH+1)  shifts/rotates since the last load, clear or reset; saturating.
- done  output  1  high when shift_cnt == WIDTH.

Behaviour:
- Reset (reset=0, asynchronous): q=RESET_VAL, shift_cnt=0, done=0. Holds while reset=0 and ignores clk.
- All updates occur on the rising clk edge, only when reset=1 and en=1. One-cycle latency: q reflects the operation on the edge where it was sampled.
- mode encoding (next q):
  - 000 HOLD: q unchanged.
  - 001 LOAD: q=d.
  - 010 SHL: q={q[WIDTH-2:0], sin_r}.
  - 011 SHR: q={sin_l, q[WIDTH-1:1]}.
  - 100 ROL: q={q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q={q[0], q[WIDTH-1:1]}.
  - 110 ASR: q={q[WIDTH-1], q[WIDTH-1:1]} (sign preserved).
  - 111 CLR: q=0 (not RESET_VAL).
- shift_cnt:
  - LOAD or CLR sets it to 0.
  - Modes 010-110 increment it, saturating at WIDTH (no wrap).
  - HOLD leaves it unchanged.
  - en=0 freezes it.
- done is decoded from registered shift_cnt, so it is glitch-free and asserts in the cycle after the WIDTH-th shift edge. It stays high through further shifts and HOLD, and clears on the edge of the next LOAD or CLR.
- sout_l/sout_r track q with no extra delay; the bit shifted out on an edge is the value visible before that edge.
- en=0 with any mode: no state change. Mode is don't-care.
- Reset asserted mid-shift sequence: immediate return to reset state. The sequence is not resumed after release.
- Unused/X inputs with en=0 must not propagate into q.
- No combinational path from d, mode, sin_l or sin_r to any output.

Test Plan:
- Reset: hold reset=0 with clk toggling, then release with en=0 -> q=RESET_VAL, shift_cnt=0, done=0. Assert reset=0 mid-cycle with q=8'hA5 -> q returns to RESET_VAL before the next clk edge.
- Load and SHL serialise (WIDTH=8): LOAD d=8'hB4, then 8 x SHL with sin_r=0 -> sout_l sequence 1,0,1,1,0,1,0,0. Final q=8'h00. done rises after the 8th edge, shift_cnt saturates at 8 through a 9th SHL.
- Rotates: LOAD 8'h81, ROL -> 8'h03. ROR x2 -> 8'hC0. shift_cnt=3, done=0.
- Right shifts: LOAD 8'h90. ASR -> 8'hC8. SHR with sin_l=0 -> 8'h64. SHR with sin_l=1 -> 8'hB2.
- Enable and hold: LOAD 8'h5A, then en=0 for 4 cycles with mode=SHL -> q stays 8'h5A, shift_cnt stays 0. Then en=1 HOLD -> unchanged.
- Clear and counter restart: after done=1, CLR -> q=8'h00, shift_cnt=0, done=0 next cycle. LOAD during a shift sequence at shift_cnt=5 -> shift_cnt=0.

Source files
------------

// File: rtl/param_shift_register.sv
// Purpose: WIDTH-bit register with parallel load, shifts, rotates, clear, serial ports and a shift counter.
// Latency: one cycle from the sampling edge to q/shift_cnt; the serial outputs and done decode directly from registers.
// Backpressure: none; en=0 freezes all state and makes mode and data don't-care.
module param_shift_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin_r,
    input  logic                         sin_l,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_l,
    output logic                         sout_r,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_t;

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_inc;

    // Saturating increment so done stays asserted through extra shifts.
    assign cnt_inc = (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + CW'(1);

    always_comb begin
        q_nxt = q;
        case (mode)
            M_HOLD: q_nxt = q;
            M_LOAD: q_nxt = d;
            M_SHL:  q_nxt = {q[WIDTH-2:0], sin_r};
            M_SHR:  q_nxt = {sin_l, q[WIDTH-1:1]};
            M_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            M_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            M_CLR:  q_nxt = '0;
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q         <= RESET_VAL;
            shift_cnt <= '0;
        end else if (en) begin
            q <= q_nxt;
            case (mode)
                M_HOLD:         shift_cnt <= shift_cnt;
                M_LOAD, M_CLR:  shift_cnt <= '0;
                default:        shift_cnt <= cnt_inc;
            endcase
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign done   = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_param_shift_register.sv
// Directed table-driven bench for param_shift_register (WIDTH=8, non-zero RESET_VAL).
module tb_param_shift_register;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] RV = 8'h3C;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                           ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sin_r, sin_l;
    logic [W-1:0]  q;
    logic          sout_l, sout_r;
    logic [CW-1:0] shift_cnt;
    logic          done;

    int checks = 0;
    int errors = 0;

    param_shift_register #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_l(sout_l), .sout_r(sout_r),
        .shift_cnt(shift_cnt), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          en;
        logic [2:0]    mode;
        logic [W-1:0]  d;
        logic          sin_r;
        logic          sin_l;
        logic [W-1:0]  q;
        logic [CW-1:0] cnt;
        logic          done;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                       input logic sr, input logic sl, input logic [W-1:0] eq,
                       input logic [CW-1:0] ec, input logic ed);
        vec_t v;
        v.name = nm; v.en = e; v.mode = m; v.d = dd; v.sin_r = sr; v.sin_l = sl;
        v.q = eq; v.cnt = ec; v.done = ed;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm, input logic [W-1:0] eq,
                               input logic [CW-1:0] ec, input logic ed);
        check({nm, ".q"}, 64'(q), 64'(eq));
        check({nm, ".cnt"}, 64'(shift_cnt), 64'(ec));
        check({nm, ".done"}, 64'(done), 64'(ed));
        check({nm, ".sout_l"}, 64'(sout_l), 64'(eq[W-1]));
        check({nm, ".sout_r"}, 64'(sout_r), 64'(eq[0]));
    endtask

    initial begin
        // Serialise 0xB4 MSB-first: sout_l after each edge is the next bit out.
        add("load_b4", 1, LOAD, 8'hB4, 0, 0, 8'hB4, 0, 0);
        add("shl1",    1, SHL,  8'h00, 0, 0, 8'h68, 1, 0);
        add("shl2",    1, SHL,  8'h00, 0, 0, 8'hD0, 2, 0);
        add("shl3",    1, SHL,  8'h00, 0, 0, 8'hA0, 3, 0);
        add("shl4",    1, SHL,  8'h00, 0, 0, 8'h40, 4, 0);
        add("shl5",    1, SHL,  8'h00, 0, 0, 8'h80, 5, 0);
        add("shl6",    1, SHL,  8'h00, 0, 0, 8'h00, 6, 0);
        add("shl7",    1, SHL,  8'h00, 0, 0, 8'h00, 7, 0);
        add("shl8",    1, SHL,  8'h00, 0, 0, 8'h00, 8, 1);
        add("shl9sat", 1, SHL,  8'h00, 0, 0, 8'h00, 8, 1);
        add("hold_dn", 1, HOLD, 8'hFF, 1, 1, 8'h00, 8, 1);
        add("clr",     1, CLR,  8'hFF, 1, 1, 8'h00, 0, 0);
        add("load_81", 1, LOAD, 8'h81, 0, 0, 8'h81, 0, 0);
        add("rol",     1, ROL,  8'h00, 0, 0, 8'h03, 1, 0);
        add("ror1",    1, ROR,  8'h00, 0, 0, 8'h81, 2, 0);
        add("ror2",    1, ROR,  8'h00, 0, 0, 8'hC0, 3, 0);
        add("load_90", 1, LOAD, 8'h90, 0, 0, 8'h90, 0, 0);
        add("asr",     1, ASR,  8'h00, 0, 0, 8'hC8, 1, 0);
        add("shr0",    1, SHR,  8'h00, 1, 0, 8'h64, 2, 0);
        add("shr1",    1, SHR,  8'h00, 0, 1, 8'hB2, 3, 0);
        add("load_5a", 1, LOAD, 8'h5A, 0, 0, 8'h5A, 0, 0);
        for (int i = 0; i < 4; i++)
            add("en0", 0, SHL, 8'hFF, 1, 1, 8'h5A, 0, 0);
        add("hold",    1, HOLD, 8'hFF, 1, 1, 8'h5A, 0, 0);
        add("shl_a",   1, SHL,  8'h00, 1, 0, 8'hB5, 1, 0);
        add("shl_b",   1, SHL,  8'h00, 1, 0, 8'h6B, 2, 0);
        add("shl_c",   1, SHL,  8'h00, 1, 0, 8'hD7, 3, 0);
        add("shl_d",   1, SHL,  8'h00, 1, 0, 8'hAF, 4, 0);
        add("shl_e",   1, SHL,  8'h00, 1, 0, 8'h5F, 5, 0);
        add("ld_mid",  1, LOAD, 8'hC3, 0, 0, 8'hC3, 0, 0);
        add("clr_ld",  1, CLR,  8'h00, 0, 0, 8'h00, 0, 0);
        add("ld_ff",   1, LOAD, 8'hFF, 0, 0, 8'hFF, 0, 0);
        add("asr_neg", 1, ASR,  8'h00, 0, 0, 8'hFF, 1, 0);

        // Reset held with clock running and a LOAD presented: must be ignored.
        reset = 1'b0; en = 1'b1; mode = LOAD; d = 8'hFF; sin_r = 1'b1; sin_l = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_state("rst_hold", RV, 0, 0);

        @(negedge clk);
        reset = 1'b1; en = 1'b0;
        @(posedge clk);
        #1;
        check_state("rst_rel", RV, 0, 0);

        foreach (tbl[i]) begin
            en = tbl[i].en; mode = tbl[i].mode; d = tbl[i].d;
            sin_r = tbl[i].sin_r; sin_l = tbl[i].sin_l;
            @(posedge clk);
            #1;
            check_state(tbl[i].name, tbl[i].q, tbl[i].cnt, tbl[i].done);
        end

        // Disabled with unknown inputs: nothing may reach q.
        en = 1'b0; mode = 3'bxxx; d = 'x; sin_r = 1'bx; sin_l = 1'bx;
        @(posedge clk);
        #1;
        check_state("en0_x", 8'hFF, 1, 0);

        // Mid-sequence asynchronous reset, then no resumption after release.
        en = 1'b1; mode = LOAD; d = 8'hA5; sin_r = 1'b0; sin_l = 1'b0;
        @(posedge clk);
        #1;
        mode = SHL;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_state("pre_rst", 8'h94, 2, 0);
        #2;
        reset = 1'b0;
        #1;
        check_state("rst_async", RV, 0, 0);
        @(negedge clk);
        reset = 1'b1; mode = HOLD;
        @(posedge clk);
        #1;
        check_state("rst_noresume", RV, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
